// File: rtl/slpf_pkg.sv
// slpf_pkg: shared constants, the counter-width helper and the per-cycle
// channel action type used by the slpf_multi glitch filter / debouncer.
package slpf_pkg;

    localparam int MODE_STRICT    = 0;  // rising edge filtered, fall immediate
    localparam int MODE_SYMMETRIC = 1;  // both edges filtered
    localparam int SLPF_MAX_DEPTH = 255;

    // Width of a counter that must hold 0 .. depth.
    function automatic int slpf_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // What a channel does on a given clock, in decreasing priority.
    typedef enum logic [2:0] {
        ACT_HOLD,      // sample agrees with output, nothing pending
        ACT_FALL_NOW,  // STRICT: any low sample drops a high output at once
        ACT_COMMIT,    // pending level has been seen DEPTH times, take it
        ACT_COUNT,     // pending level seen again, keep counting
        ACT_ABANDON    // pending level went away before DEPTH, report glitch
    } slpf_act_e;

endpackage

// File: rtl/slpf_chan.sv
// slpf_chan: one filter channel -- optional synchroniser chain, qualification
// counter, registered output level and registered rise/fall/glitch pulses.
//
// Ports:
//   clk    - system clock, all state on the rising edge
//   nrst   - synchronous active-low reset
//   din    - raw, possibly asynchronous, input
//   out    - filtered level (flop)
//   rise   - one-clock pulse when out goes 0->1 (flop)
//   fall   - one-clock pulse when out goes 1->0 (flop)
//   glitch - one-clock pulse when a pending transition is abandoned (flop)
module slpf_chan
    import slpf_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = MODE_STRICT,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic din,
    output logic out,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int            CW       = slpf_cnt_w(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    logic s;  // synchronised sample seen by the filter

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = din;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            // NOTE: every combinational output gets a default before any
            // conditional logic, so no path leaves it unassigned (no latch).
            always_comb begin
                sync_d[0] = din;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            // NOTE: state is updated with non-blocking assignments so all
            // flops sample their inputs from before the edge, like hardware.
            always_ff @(posedge clk) begin
                if (!nrst) begin
                    sync_q <= {SYNC_STAGES{RESET_VAL}};
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          glitch_q, glitch_d;
    slpf_act_e     act;

    // Classify the cycle. cnt never exceeds DEPTH-1, so "not the last count"
    // is the same as "below DEPTH-1".
    always_comb begin
        act = ACT_HOLD;
        if (MODE == MODE_STRICT && out_q && !s) begin
            act = ACT_FALL_NOW;
        end else if (s != out_q) begin
            act = (cnt_q == CNT_LAST) ? ACT_COMMIT : ACT_COUNT;
        end else if (cnt_q != '0) begin
            act = ACT_ABANDON;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        out_d    = out_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        unique case (act)
            ACT_FALL_NOW: begin
                out_d  = 1'b0;
                fall_d = 1'b1;
                cnt_d  = '0;
            end
            ACT_COMMIT: begin
                out_d  = s;
                rise_d = s;
                fall_d = !s;
                cnt_d  = '0;
            end
            ACT_COUNT: begin
                cnt_d = cnt_q + CW'(1);
            end
            ACT_ABANDON: begin
                cnt_d    = '0;
                glitch_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q    <= '0;
            out_q    <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign out    = out_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign glitch = glitch_q;

endmodule

// File: rtl/slpf_multi.sv
// slpf_multi: WIDTH independent glitch filter / debouncer channels for noisy
// inputs. Each channel is synchronised and must hold a new level for DEPTH
// consecutive clocks before its output follows (STRICT mode: falls are
// immediate). Edge and glitch pulses are reported per channel.
//
// Ports:
//   clk    - system clock
//   nrst   - synchronous active-low reset
//   in     - [WIDTH] raw inputs
//   out    - [WIDTH] filtered levels (registered)
//   rise   - [WIDTH] one-clock pulse when out[i] goes 0->1
//   fall   - [WIDTH] one-clock pulse when out[i] goes 1->0
//   glitch - [WIDTH] one-clock pulse when a pending change is abandoned
module slpf_multi
    import slpf_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = MODE_STRICT,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] glitch
);

    generate
        if (WIDTH < 1 || WIDTH > 16 ||
            DEPTH < 1 || DEPTH > SLPF_MAX_DEPTH ||
            SYNC_STAGES < 0 || SYNC_STAGES > 3 ||
            (MODE != MODE_STRICT && MODE != MODE_SYMMETRIC)) begin : g_bad_param
            $error("slpf_multi: parameter out of range");
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        slpf_chan #(
            .DEPTH      (DEPTH),
            .SYNC_STAGES(SYNC_STAGES),
            .MODE       (MODE),
            .RESET_VAL  (RESET_VAL)
        ) u_chan (
            .clk   (clk),
            .nrst  (nrst),
            .din   (in[i]),
            .out   (out[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .glitch(glitch[i])
        );
    end

endmodule

// File: tb/tb_slpf_multi.sv
// tb_slpf_multi: directed table-driven bench for slpf_multi. Three instances:
//   a: STRICT,    DEPTH=3, SYNC_STAGES=2
//   b: SYMMETRIC, DEPTH=3, SYNC_STAGES=2
//   c: SYMMETRIC, DEPTH=1, SYNC_STAGES=0
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Each table row is one rising edge.
module tb_slpf_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic [3:0] in_a, in_b, in_c;
    logic [3:0] out_a, rise_a, fall_a, glitch_a;
    logic [3:0] out_b, rise_b, fall_b, glitch_b;
    logic [3:0] out_c, rise_c, fall_c, glitch_c;

    slpf_multi #(.WIDTH(4), .DEPTH(3), .SYNC_STAGES(2), .MODE(0), .RESET_VAL(1'b0)) u_dut_a (
        .clk(clk), .nrst(nrst), .in(in_a),
        .out(out_a), .rise(rise_a), .fall(fall_a), .glitch(glitch_a)
    );

    slpf_multi #(.WIDTH(4), .DEPTH(3), .SYNC_STAGES(2), .MODE(1), .RESET_VAL(1'b0)) u_dut_b (
        .clk(clk), .nrst(nrst), .in(in_b),
        .out(out_b), .rise(rise_b), .fall(fall_b), .glitch(glitch_b)
    );

    slpf_multi #(.WIDTH(4), .DEPTH(1), .SYNC_STAGES(0), .MODE(1), .RESET_VAL(1'b0)) u_dut_c (
        .clk(clk), .nrst(nrst), .in(in_c),
        .out(out_c), .rise(rise_c), .fall(fall_c), .glitch(glitch_c)
    );

    typedef struct {
        int         sel;   // 0 = a, 1 = b, 2 = c
        logic       nrst;
        logic [3:0] din;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] glitch;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int rep, input int sel, input logic n, input logic [3:0] d,
                       input logic [3:0] o, input logic [3:0] r,
                       input logic [3:0] f, input logic [3:0] g);
        vec_t v;
        v.sel = sel; v.nrst = n; v.din = d;
        v.out = o; v.rise = r; v.fall = f; v.glitch = g;
        for (int k = 0; k < rep; k++) vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] o, r, f, g;
        int         n;

        nrst = 1'b0;
        in_a = 4'h0;
        in_b = 4'h0;
        in_c = 4'h0;

        // ---- a: reset with in high, then release (5-clock latency)
        add(4, 0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4, 0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        // ---- a: drop ch0 so it starts low (STRICT fall after 2 sync stages)
        add(2, 0, 1'b1, 4'hE, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hE, 4'hE, 4'h0, 4'h1, 4'h0);
        add(1, 0, 1'b1, 4'hE, 4'hE, 4'h0, 4'h0, 4'h0);
        // ---- a: 2-clock pulse on ch0 is filtered, one glitch
        add(2, 0, 1'b1, 4'hF, 4'hE, 4'h0, 4'h0, 4'h0);
        add(2, 0, 1'b1, 4'hE, 4'hE, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hE, 4'hE, 4'h0, 4'h0, 4'h1);
        add(1, 0, 1'b1, 4'hE, 4'hE, 4'h0, 4'h0, 4'h0);
        // ---- a: 3-clock high run on ch0 is accepted at clock 5
        add(4, 0, 1'b1, 4'hF, 4'hE, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hF, 4'hF, 4'h1, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        // ---- a: STRICT 1-clock drop: immediate fall, re-rise after 3 highs
        add(1, 0, 1'b1, 4'hE, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hF, 4'hE, 4'h0, 4'h1, 4'h0);
        add(2, 0, 1'b1, 4'hF, 4'hE, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hF, 4'hF, 4'h1, 4'h0, 4'h0);
        add(1, 0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);

        // ---- b: bring ch0 and ch2 high
        add(4, 1, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1, 1'b1, 4'h5, 4'h5, 4'h5, 4'h0, 4'h0);
        add(1, 1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0);
        // ---- b: SYMMETRIC 1-clock drop on ch0 is a glitch
        add(1, 1, 1'b1, 4'h4, 4'h5, 4'h0, 4'h0, 4'h0);
        add(2, 1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0);
        add(1, 1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 4'h1);
        add(1, 1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0);
        // ---- b: fast toggle gives repeated glitches, out unchanged
        add(1, 1, 1'b1, 4'h4, 4'h5, 4'h0, 4'h0, 4'h0);
        add(1, 1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0);
        add(1, 1, 1'b1, 4'h4, 4'h5, 4'h0, 4'h0, 4'h0);
        add(1, 1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 4'h1);
        add(1, 1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0);
        add(1, 1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 4'h1);
        add(1, 1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0);
        // ---- b: 3-clock drop on ch0 is accepted at clock 5
        add(4, 1, 1'b1, 4'h4, 4'h5, 4'h0, 4'h0, 4'h0);
        add(1, 1, 1'b1, 4'h4, 4'h4, 4'h0, 4'h1, 4'h0);
        add(1, 1, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
        // ---- b: ch1 rises and ch2 falls on the same clock
        add(4, 1, 1'b1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 1, 1'b1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h0);
        add(1, 1, 1'b1, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0);

        // ---- c: DEPTH=1, no synchroniser: out = in one clock later
        add(1, 2, 1'b1, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0);
        add(1, 2, 1'b1, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0);
        add(1, 2, 1'b1, 4'h5, 4'h5, 4'h4, 4'h2, 4'h0);
        add(1, 2, 1'b1, 4'hA, 4'hA, 4'hA, 4'h5, 4'h0);
        add(1, 2, 1'b1, 4'hF, 4'hF, 4'h5, 4'h0, 4'h0);
        add(1, 2, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            nrst = vecs[i].nrst;
            case (vecs[i].sel)
                0:       in_a = vecs[i].din;
                1:       in_b = vecs[i].din;
                default: in_c = vecs[i].din;
            endcase
            @(posedge clk);
            #1;
            case (vecs[i].sel)
                0:       begin o = out_a; r = rise_a; f = fall_a; g = glitch_a; end
                1:       begin o = out_b; r = rise_b; f = fall_b; g = glitch_b; end
                default: begin o = out_c; r = rise_c; f = fall_c; g = glitch_c; end
            endcase
            check("out",    i, o, vecs[i].out);
            check("rise",   i, r, vecs[i].rise);
            check("fall",   i, f, vecs[i].fall);
            check("glitch", i, g, vecs[i].glitch);
        end

        // ---- a: reset mid-count discards the partial count
        repeat (2) begin
            @(negedge clk);
            nrst = 1'b0;
            in_a = 4'h0;
        end
        @(negedge clk);
        nrst = 1'b1;
        in_a = 4'h1;
        repeat (4) @(posedge clk);   // sync x2, then count reaches 2
        #1;
        check("midrst_pre_out", 0, out_a, 4'h0);
        @(negedge clk);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_reset_out", 0, out_a, 4'h0);
        @(negedge clk);
        nrst = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (out_a[0]) break;
        end
        check("midrst_latency", 0, n, 5);
        check("midrst_rise", 0, rise_a, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
